// File: rtl/req_apb_bridge.sv
// Crossbar slave-port to APB3 bridge: one APB transfer per level-request beat,
// with a PREADY timeout that turns a hung peripheral into an error acknowledge.
module req_apb_bridge #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    input  logic              s_req,
    input  logic              s_cmd,
    input  logic [31:0]       s_addr,
    input  logic [31:0]       s_wdata,
    output logic              s_ack,
    output logic [31:0]       s_rdata,
    output logic              s_err,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [31:0]       PWDATA,
    input  logic [31:0]       PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {StIdle, StSetup, StAccess, StAck, StTurn} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               psel_d, penable_d, ack_d, err_d, pwrite_d;
    logic [ADDR_W-1:0]  paddr_d;
    logic [31:0]        pwdata_d, rdata_d;

    // Only the low ADDR_W address bits reach the peripheral.
    logic unused_addr;
    assign unused_addr = ^{1'b0, s_addr};

    // Outputs are registered, so each is computed from the state being entered.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        paddr_d   = PADDR;
        pwrite_d  = PWRITE;
        pwdata_d  = PWDATA;
        rdata_d   = s_rdata;
        unique case (state_q)
            StIdle: begin
                if (s_req) begin
                    state_d  = StSetup;
                    psel_d   = 1'b1;
                    pwrite_d = s_cmd;
                    paddr_d  = s_addr[ADDR_W-1:0];
                    pwdata_d = s_wdata;
                end
            end
            StSetup: begin
                state_d   = StAccess;
                psel_d    = 1'b1;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            StAccess: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                // PREADY takes priority over an expiring timeout.
                if (PREADY) begin
                    state_d   = StAck;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    ack_d     = 1'b1;
                    err_d     = PSLVERR;
                    if (!PWRITE) rdata_d = PRDATA;
                end else if (TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d   = StAck;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    ack_d     = 1'b1;
                    err_d     = 1'b1;
                    if (!PWRITE) rdata_d = ERR_DATA;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StAck:   state_d = StTurn;
            StTurn:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            s_ack   <= 1'b0;
            s_err   <= 1'b0;
            PADDR   <= '0;
            PWRITE  <= 1'b0;
            PWDATA  <= '0;
            s_rdata <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            PSEL    <= psel_d;
            PENABLE <= penable_d;
            s_ack   <= ack_d;
            s_err   <= err_d;
            PADDR   <= paddr_d;
            PWRITE  <= pwrite_d;
            PWDATA  <= pwdata_d;
            s_rdata <= rdata_d;
        end
    end

endmodule

// File: tb/tb_req_apb_bridge.sv
// Randomized self-checking bench for req_apb_bridge against a beat-level reference model.
module tb_req_apb_bridge;

    localparam int unsigned TO   = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        PCLK = 1'b0;
    logic        PRESETN;
    logic        s_req, s_cmd, s_ack, s_err;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [15:0] PADDR;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [31:0] PWDATA, PRDATA;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          ack_cyc = 0;
    logic [31:0] mdl_rdata = '0;

    req_apb_bridge #(
        .ADDR_W  (16),
        .TIMEOUT (TO),
        .ERR_DATA(ERRD)
    ) dut (
        .PCLK   (PCLK),
        .PRESETN(PRESETN),
        .s_req  (s_req),
        .s_cmd  (s_cmd),
        .s_addr (s_addr),
        .s_wdata(s_wdata),
        .s_ack  (s_ack),
        .s_rdata(s_rdata),
        .s_err  (s_err),
        .PADDR  (PADDR),
        .PSEL   (PSEL),
        .PENABLE(PENABLE),
        .PWRITE (PWRITE),
        .PWDATA (PWDATA),
        .PRDATA (PRDATA),
        .PREADY (PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One beat: w = PREADY wait cycles (-1 = never ready). Starts and ends on a falling edge.
    task automatic run_beat(input logic cmd, input logic [31:0] addr, input logic [31:0] wdata,
                            input int w, input logic [31:0] prdata, input logic slverr,
                            input logic hold, input string tag);
        int   exp_k, n_cyc, pen;
        logic tout, seen, stable;
        exp_k = (w < 0 || w > int'(TO)) ? int'(TO) : w;
        tout  = (exp_k != w);
        s_req = 1'b1; s_cmd = cmd; s_addr = addr; s_wdata = wdata;
        PRDATA = prdata; PSLVERR = slverr; PREADY = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge PCLK);
            seen = PSEL;
        end
        check_eq({tag, ".setup_seen"}, 32'(seen), 32'd1);
        if (!seen) return;
        n_cyc = cyc;
        if (!hold) s_req = 1'b0;
        check_eq({tag, ".setup_penable"}, 32'(PENABLE), 32'd0);
        check_eq({tag, ".paddr"}, 32'(PADDR), 32'(addr[15:0]));
        check_eq({tag, ".pwrite"}, 32'(PWRITE), 32'(cmd));
        check_eq({tag, ".pwdata"}, PWDATA, wdata);
        pen = 0; seen = 1'b0; stable = 1'b1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge PCLK);
            if (s_ack) begin
                seen = 1'b1;
            end else if (PSEL && PENABLE) begin
                pen++;
                if (PADDR !== addr[15:0] || PWRITE !== cmd || PWDATA !== wdata) stable = 1'b0;
                PREADY = (pen - 1 == w);
            end
        end
        PREADY = 1'b0;
        check_eq({tag, ".ack_seen"}, 32'(seen), 32'd1);
        check_eq({tag, ".ack_latency"}, 32'(cyc - n_cyc), 32'(2 + exp_k));
        check_eq({tag, ".access_cycles"}, 32'(pen), 32'(exp_k + 1));
        check_eq({tag, ".apb_stable"}, 32'(stable), 32'd1);
        check_eq({tag, ".err"}, 32'(s_err), 32'(tout ? 1'b1 : slverr));
        check_eq({tag, ".ack_psel"}, 32'({PSEL, PENABLE}), 32'd0);
        if (!cmd) mdl_rdata = tout ? ERRD : prdata;
        check_eq({tag, ".rdata"}, s_rdata, mdl_rdata);
        ack_cyc = cyc;
        @(negedge PCLK);
        check_eq({tag, ".ack_pulse"}, 32'({s_ack, s_err}), 32'd0);
        check_eq({tag, ".turn_psel"}, 32'(PSEL), 32'd0);
        check_eq({tag, ".rdata_hold"}, s_rdata, mdl_rdata);
    endtask

    initial begin
        int          prev_ack, r, w;
        logic        seen;
        PRESETN = 1'b0; s_req = 1'b0; s_cmd = 1'b0; s_addr = '0; s_wdata = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        #1;
        check_eq("rst.outputs", 32'({s_ack, s_err, PSEL, PENABLE, PWRITE}), 32'd0);
        check_eq("rst.rdata", s_rdata, 32'd0);
        check_eq("rst.paddr_pwdata", 32'(PADDR) | PWDATA, 32'd0);
        repeat (2) @(negedge PCLK);
        PRESETN = 1'b1;
        @(negedge PCLK);

        run_beat(1'b1, 32'h8000_0010, 32'h1234_5678, 0, 32'h0, 1'b0, 1'b0, "wr0");
        run_beat(1'b0, 32'h0000_0040, 32'h0, 3, 32'hCAFE_0001, 1'b0, 1'b0, "rd3w");

        for (int b = 0; b < 4; b++) begin
            prev_ack = ack_cyc;
            run_beat(1'b0, 32'h20 + 32'(b), 32'h0, 0, 32'hB000_0000 + 32'(b), 1'b0, b != 3,
                     $sformatf("burst%0d", b));
            if (b > 0) check_eq($sformatf("burst%0d.spacing", b), 32'(ack_cyc - prev_ack), 32'd5);
        end

        run_beat(1'b1, 32'h0000_0077, 32'hA5A5_A5A5, 1, 32'h1111_1111, 1'b1, 1'b0, "wr_slverr");
        run_beat(1'b0, 32'h0000_0080, 32'h0, -1, 32'h2222_2222, 1'b0, 1'b0, "rd_tout");
        run_beat(1'b0, 32'h0000_0081, 32'h0, 2, 32'h3333_3333, 1'b0, 1'b0, "after_tout");
        run_beat(1'b0, 32'h0000_0082, 32'h0, int'(TO), 32'h4444_4444, 1'b0, 1'b0, "rdy_at_to");
        run_beat(1'b1, 32'h0000_0083, 32'h5555_5555, -1, 32'h0, 1'b0, 1'b0, "wr_tout");

        // Asynchronous reset during ACCESS, between clock edges.
        s_req = 1'b1; s_cmd = 1'b0; s_addr = 32'h90; PREADY = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge PCLK);
            seen = PENABLE;
        end
        check_eq("rst_mid.reached_access", 32'(seen), 32'd1);
        s_req = 1'b0;
        #2 PRESETN = 1'b0;
        #1;
        check_eq("rst_mid.psel_penable", 32'({PSEL, PENABLE}), 32'd0);
        check_eq("rst_mid.ack_err", 32'({s_ack, s_err}), 32'd0);
        mdl_rdata = '0;
        check_eq("rst_mid.rdata", s_rdata, mdl_rdata);
        @(negedge PCLK);
        PRESETN = 1'b1;
        @(negedge PCLK);
        run_beat(1'b0, 32'h0000_0091, 32'h0, 0, 32'h6666_6666, 1'b0, 1'b0, "post_rst");

        for (int b = 0; b < 24; b++) begin
            r = int'($urandom_range(0, 11));
            w = (r == 11) ? -1 : r;
            run_beat(1'($urandom), $urandom, $urandom, w, $urandom, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), $sformatf("rnd%0d", b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
